// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO serial receive path.
package gpio_pkg;

  localparam int GPIO_DSIZE        = 8;
  localparam int GPIO_CLKS_PER_BIT = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/gpio_rx_fifo.sv
// Single-clock first-word-fall-through FIFO; a write is taken when not full
// or when a read in the same cycle frees the slot.
module gpio_rx_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [DSIZE-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [DSIZE-1:0] rd_data_o,
  output logic             empty_o,
  output logic             wr_ok_o,
  output logic [ASIZE:0]   level_o
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [ASIZE:0]   wr_ptr_q, wr_ptr_d;
  logic [ASIZE:0]   rd_ptr_q, rd_ptr_d;
  logic [DSIZE-1:0] mem_q [DEPTH];
  logic             full;
  logic             rd_do;
  logic             wr_do;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ASIZE] != rd_ptr_q[ASIZE]) &&
                     (wr_ptr_q[ASIZE-1:0] == rd_ptr_q[ASIZE-1:0]);
  assign rd_do     = rd_en_i && !empty_o;
  assign wr_ok_o   = !full || rd_do;
  assign wr_do     = wr_en_i && wr_ok_o;
  assign rd_data_o = mem_q[rd_ptr_q[ASIZE-1:0]];
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign wr_ptr_d  = wr_do ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = rd_do ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_do) mem_q[wr_ptr_q[ASIZE-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/gpio_serial_rx.sv
// GPIO serial receiver: synchronizer, start/8-data/stop frame recovery
// (MSB first), receive FIFO, per-byte interrupt and sticky error flags.
module gpio_serial_rx
  import gpio_pkg::*;
#(
  parameter int DSIZE        = GPIO_DSIZE,
  parameter int ASIZE        = 4,
  parameter int CLKS_PER_BIT = GPIO_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             gpio_in,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic [ASIZE:0]   level,
  output logic [DSIZE-1:0] pin_status,
  output logic             interrupt,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DSIZE);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DSIZE - 1);

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DSIZE-1:0] shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             sync1_q, s_in_q;
  logic [DSIZE-1:0] pin_q, pin_d;
  logic             int_q, fe_q, fe_d, ov_q, ov_d;
  logic             stop_good, stop_bad;
  logic             fifo_empty, wr_ok;

  gpio_rx_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (stop_good),
    .wr_data_i (shift_q),
    .rd_en_i   (rready),
    .rd_data_o (rdata),
    .empty_o   (fifo_empty),
    .wr_ok_o   (wr_ok),
    .level_o   (level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    // Re-arm only after the line has been seen idle, so a stuck-low pin cannot retrigger.
    if (state_q == IDLE && s_in_q) armed_d = 1'b1;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (armed_q && !s_in_q) begin
            state_d = START;
            armed_d = 1'b0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = s_in_q ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d   = '0;
            shift_d = {shift_q[DSIZE-2:0], s_in_q};
            if (bit_q == BIT_LAST) state_d = STOP;
            else                   bit_d   = bit_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d     = '0;
            state_d   = IDLE;
            stop_good = s_in_q;
            stop_bad  = !s_in_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Set events take priority over a simultaneous clear.
  always_comb begin
    pin_d = stop_good ? shift_q : pin_q;
    fe_d  = (fe_q && !clr_err) || stop_bad;
    ov_d  = (ov_q && !clr_err) || (stop_good && !wr_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      s_in_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      pin_q   <= '0;
      int_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= gpio_in;
      s_in_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      pin_q   <= pin_d;
      int_q   <= stop_good && wr_ok;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rvalid     = !fifo_empty;
  assign pin_status = pin_q;
  assign interrupt  = int_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_gpio_serial_rx.sv
// Directed bench for gpio_serial_rx: a queue-based receive model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_gpio_serial_rx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n, enable, gpio_in, rready, clr_err;
  logic [7:0] rdata, pin_status;
  logic       rvalid, interrupt, frame_err, overrun;
  logic [4:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] m_pin;
  logic       m_int, m_fe, m_ov;

  gpio_serial_rx #(.DSIZE(8), .ASIZE(4), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .gpio_in    (gpio_in),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .level      (level),
    .pin_status (pin_status),
    .interrupt  (interrupt),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pin = 8'h00;
    m_int = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
  endtask

  // Every falling edge: outputs must match the model; the interrupt is expected for one cycle only.
  always @(negedge clk) begin
    chk("rvalid", {31'd0, rvalid}, {31'd0, q.size() != 0});
    chk("level", {27'd0, level}, q.size());
    if (q.size() != 0) chk("rdata", {24'd0, rdata}, {24'd0, q[0]});
    chk("pin_status", {24'd0, pin_status}, {24'd0, m_pin});
    chk("interrupt", {31'd0, interrupt}, {31'd0, m_int});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
    m_int = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits MSB first and the stop bit; returns 1 time unit
  // after the edge on which the frame's result becomes visible (pin edge + 41).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    logic [9:0] bits;
    bit         do_pop;
    bit         accept;
    bits    = {1'b0, b, stop};
    gpio_in = 1'b1;
    repeat (2) tick();
    for (int i = 9; i >= 0; i--) begin
      gpio_in = bits[i];
      repeat (CPB) tick();
    end
    gpio_in = 1'b1;
    rready  = pop_at_stop;
    @(posedge clk);
    if (stop) begin
      do_pop = pop_at_stop && (q.size() > 0);
      accept = (q.size() < DEPTH) || do_pop;
      if (do_pop) void'(q.pop_front());
      m_pin = b;
      if (accept) begin
        q.push_back(b);
        m_int = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else begin
      m_fe = 1'b1;
    end
    #1;
    rready = 1'b0;
  endtask

  task automatic pop_one();
    rready = 1'b1;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    #1;
    rready = 1'b0;
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    @(posedge clk);
    m_fe = 1'b0;
    m_ov = 1'b0;
    #1;
    clr_err = 1'b0;
  endtask

  task automatic partial_frame();
    gpio_in = 1'b0;
    repeat (CPB) tick();
    gpio_in = 1'b1;
    repeat (CPB) tick();
    gpio_in = 1'b0;
    repeat (CPB) tick();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_level"}, {27'd0, level}, 32'd0);
    chk({tag, "_pin"}, {24'd0, pin_status}, 32'd0);
    chk({tag, "_int"}, {31'd0, interrupt}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    gpio_in = 1'b1;
    rready  = 1'b0;
    clr_err = 1'b0;
    model_reset();
    repeat (3) tick();
    chk_reset_values("reset");
    rst_n = 1'b1;
    repeat (4) tick();

    // Single frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_rvalid", {31'd0, rvalid}, 32'd1);
    chk("a5_rdata", {24'd0, rdata}, 32'hA5);
    chk("a5_level", {27'd0, level}, 32'd1);
    chk("a5_pin", {24'd0, pin_status}, 32'hA5);
    chk("a5_int", {31'd0, interrupt}, 32'd1);
    tick();
    chk("a5_int_pulse", {31'd0, interrupt}, 32'd0);
    pop_one();
    chk("a5_pop_level", {27'd0, level}, 32'd0);

    // One-cycle glitches, each followed closely by a real frame
    for (int g = 0; g < 3; g++) begin
      gpio_in = 1'b0;
      tick();
      gpio_in = 1'b1;
      repeat (2) tick();
    end
    chk("glitch_level", {27'd0, level}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    gpio_in = 1'b0;
    tick();
    gpio_in = 1'b1;
    repeat (2) tick();
    send_frame(8'h96, 1'b1, 1'b0);
    chk("post_glitch_rdata", {24'd0, rdata}, 32'h96);
    pop_one();

    // Bad stop bit, then clear, then a good copy
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    chk("ferr_level", {27'd0, level}, 32'd0);
    chk("ferr_pin_kept", {24'd0, pin_status}, 32'h96);
    clear_errs();
    chk("ferr_cleared", {31'd0, frame_err}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("good_3c_rdata", {24'd0, rdata}, 32'h3C);
    chk("good_3c_level", {27'd0, level}, 32'd1);
    pop_one();

    // Overrun: 17 frames without draining
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("ovr_level", {27'd0, level}, 32'd16);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_pin", {24'd0, pin_status}, 32'h10);
    clear_errs();
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", {24'd0, rdata}, i);
      pop_one();
    end
    pop_one();
    chk("empty_pop_level", {27'd0, level}, 32'd0);

    // Full FIFO, pop coincides with push
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    chk("refill_level", {27'd0, level}, 32'd16);
    send_frame(8'h55, 1'b1, 1'b1);
    chk("fullpop_level", {27'd0, level}, 32'd16);
    chk("fullpop_ovr", {31'd0, overrun}, 32'd0);
    chk("fullpop_head", {24'd0, rdata}, 32'h21);
    chk("fullpop_int", {31'd0, interrupt}, 32'd1);
    for (int i = 0; i < 16; i++) pop_one();
    chk("fullpop_drained", {27'd0, level}, 32'd0);

    // Enable dropped mid-DATA
    partial_frame();
    enable  = 1'b0;
    gpio_in = 1'b1;
    repeat (8) tick();
    enable = 1'b1;
    repeat (4) tick();
    send_frame(8'h81, 1'b1, 1'b0);
    chk("en_level", {27'd0, level}, 32'd1);
    chk("en_rdata", {24'd0, rdata}, 32'h81);

    // Asynchronous reset mid-frame with data and a flag pending
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("pre_rst_ferr", {31'd0, frame_err}, 32'd1);
    partial_frame();
    rst_n   = 1'b0;
    gpio_in = 1'b1;
    model_reset();
    #1;
    chk_reset_values("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("post_rst_rdata", {24'd0, rdata}, 32'h5A);
    chk("post_rst_level", {27'd0, level}, 32'd1);
    pop_one();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
